// File: rtl/alu_seq_ctrl_if.sv
// Command, result and external-ALU signal bundle for alu_seq_ctrl.
// slave = controller side, master = upstream/downstream/ALU side.
`timescale 1ns/1ps
interface alu_seq_ctrl_if;
   logic        in_valid;
   logic        in_ready;
   logic [3:0]  in_op;
   logic [31:0] in_a;
   logic [31:0] in_b;
   logic [31:0] alu_a;
   logic [31:0] alu_b;
   logic [2:0]  alu_func;
   logic [31:0] alu_out;
   logic        alu_c_out;
   logic        res_valid;
   logic        res_ready;
   logic [31:0] res_data;
   logic        res_carry;

   modport slave (
      input  in_valid, in_op, in_a, in_b, alu_out, alu_c_out, res_ready,
      output in_ready, alu_a, alu_b, alu_func, res_valid, res_data, res_carry
   );

   modport master (
      output in_valid, in_op, in_a, in_b, alu_out, alu_c_out, res_ready,
      input  in_ready, alu_a, alu_b, alu_func, res_valid, res_data, res_carry
   );
endinterface

// File: rtl/alu_seq_ctrl.sv
// Sequencer that runs single ALU ops and iterative SRL/SLL through an external ALU.
// Shift support is compiled in only when ALU_SEQ_SHIFT_EN is defined.
`timescale 1ns/1ps
module alu_seq_ctrl (
   input logic            clk,
   input logic            rst_n,
   alu_seq_ctrl_if.slave  bus
);

   typedef enum logic [1:0] {
      StIdle  = 2'd0,
      StExec  = 2'd1,
`ifdef ALU_SEQ_SHIFT_EN
      StShift = 2'd2,
`endif
      StDone  = 2'd3
   } state_e;

   state_e      state_q, state_d;
   logic [3:0]  opr_op_q, opr_op_d;
   logic [31:0] opr_a_q, opr_a_d;
   logic [31:0] opr_b_q, opr_b_d;
   logic [31:0] res_data_q, res_data_d;
   logic        res_carry_q, res_carry_d;
`ifdef ALU_SEQ_SHIFT_EN
   logic [31:0] acc_q, acc_d;
   logic [4:0]  cnt_q, cnt_d;
`endif

   logic [31:0] alu_a, alu_b;
   logic [2:0]  alu_func;

   always_comb begin
      state_d     = state_q;
      opr_op_d    = opr_op_q;
      opr_a_d     = opr_a_q;
      opr_b_d     = opr_b_q;
      res_data_d  = res_data_q;
      res_carry_d = res_carry_q;
`ifdef ALU_SEQ_SHIFT_EN
      acc_d       = acc_q;
      cnt_d       = cnt_q;
`endif
      alu_a       = opr_a_q;
      alu_b       = opr_b_q;
      alu_func    = 3'b000;

      case (state_q)
         StIdle: begin
            if (bus.in_valid) begin
               opr_op_d = bus.in_op;
               opr_a_d  = bus.in_a;
               opr_b_d  = bus.in_b;
`ifdef ALU_SEQ_SHIFT_EN
               acc_d    = bus.in_a;
               cnt_d    = bus.in_b[4:0];
`endif
               if (!bus.in_op[3]) begin
                  state_d = StExec;
`ifdef ALU_SEQ_SHIFT_EN
               end else if (bus.in_op[3:1] == 3'b100) begin
                  if (bus.in_b[4:0] == 5'd0) begin
                     res_data_d  = bus.in_a;
                     res_carry_d = 1'b0;
                     state_d     = StDone;
                  end else begin
                     state_d = StShift;
                  end
`endif
               end else begin
                  res_data_d  = 32'd0;
                  res_carry_d = 1'b0;
                  state_d     = StDone;
               end
            end
         end
         StExec: begin
            alu_func = opr_op_q[2:0];
            // func 111 is reserved: result forced to zero regardless of the ALU
            if (opr_op_q[2:0] == 3'b111) begin
               res_data_d  = 32'd0;
               res_carry_d = 1'b0;
            end else begin
               res_data_d  = bus.alu_out;
               res_carry_d = bus.alu_c_out;
            end
            state_d = StDone;
         end
`ifdef ALU_SEQ_SHIFT_EN
         StShift: begin
            alu_a = acc_q;
            if (opr_op_q[0]) begin
               // SLL as acc + acc
               alu_b    = acc_q;
               alu_func = 3'b000;
            end else begin
               alu_func = 3'b110;
            end
            acc_d = bus.alu_out;
            cnt_d = cnt_q - 5'd1;
            if (cnt_q == 5'd1) begin
               res_data_d  = bus.alu_out;
               res_carry_d = opr_op_q[0] ? bus.alu_c_out : acc_q[0];
               state_d     = StDone;
            end
         end
`endif
         StDone: begin
            if (bus.res_ready) state_d = StIdle;
         end
         default: state_d = StIdle;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= StIdle;
         opr_op_q    <= 4'd0;
         opr_a_q     <= 32'd0;
         opr_b_q     <= 32'd0;
         res_data_q  <= 32'd0;
         res_carry_q <= 1'b0;
`ifdef ALU_SEQ_SHIFT_EN
         acc_q       <= 32'd0;
         cnt_q       <= 5'd0;
`endif
      end else begin
         state_q     <= state_d;
         opr_op_q    <= opr_op_d;
         opr_a_q     <= opr_a_d;
         opr_b_q     <= opr_b_d;
         res_data_q  <= res_data_d;
         res_carry_q <= res_carry_d;
`ifdef ALU_SEQ_SHIFT_EN
         acc_q       <= acc_d;
         cnt_q       <= cnt_d;
`endif
      end
   end

   assign bus.in_ready  = (state_q == StIdle);
   assign bus.res_valid = (state_q == StDone);
   assign bus.res_data  = res_data_q;
   assign bus.res_carry = res_carry_q;
   assign bus.alu_a     = alu_a;
   assign bus.alu_b     = alu_b;
   assign bus.alu_func  = alu_func;

endmodule

// File: tb/tb_alu_seq_ctrl.sv
// Directed self-checking bench for alu_seq_ctrl with a behavioural ALU model.
// Shift expectations follow whether ALU_SEQ_SHIFT_EN is defined.
`timescale 1ns/1ps
module tb_alu_seq_ctrl;

`ifdef ALU_SEQ_SHIFT_EN
   localparam bit ShiftEn = 1'b1;
`else
   localparam bit ShiftEn = 1'b0;
`endif

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   int   n_total = 0;
   int   n_pass = 0;

   alu_seq_ctrl_if bus ();

   alu_seq_ctrl dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus.slave)
   );

   always #5 clk = ~clk;

   // ALU model: 000 add, 001 sub (carry = borrow), 010 and, 011 or, 100 xor, 101 pass A,
   // 110 shift right by one (carry = bit shifted out), 111 zero
   always_comb begin
      logic [32:0] sum;
      sum = {1'b0, bus.alu_a} + {1'b0, bus.alu_b};
      bus.alu_out   = 32'd0;
      bus.alu_c_out = 1'b0;
      case (bus.alu_func)
         3'b000: begin bus.alu_out = sum[31:0]; bus.alu_c_out = sum[32]; end
         3'b001: begin bus.alu_out = bus.alu_a - bus.alu_b; bus.alu_c_out = bus.alu_a < bus.alu_b; end
         3'b010: bus.alu_out = bus.alu_a & bus.alu_b;
         3'b011: bus.alu_out = bus.alu_a | bus.alu_b;
         3'b100: bus.alu_out = bus.alu_a ^ bus.alu_b;
         3'b101: bus.alu_out = bus.alu_a;
         3'b110: begin bus.alu_out = bus.alu_a >> 1; bus.alu_c_out = bus.alu_a[0]; end
         default: bus.alu_out = 32'd0;
      endcase
   end

   // Issue one command (called away from a clock edge) and wait for res_valid.
   // lat counts rising edges from the accepting edge (inclusive) to res_valid.
   task automatic do_op(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                        output int lat, output logic [31:0] data, output logic carry,
                        output logic [2:0] func1, output logic [31:0] done_alu_a);
      bus.in_valid = 1'b1;
      bus.in_op    = op;
      bus.in_a     = a;
      bus.in_b     = b;
      @(posedge clk);
      #1;
      bus.in_valid = 1'b0;
      func1 = bus.alu_func;
      lat = 1;
      while (!bus.res_valid && lat < 64) begin
         @(posedge clk);
         #1;
         lat++;
      end
      data       = bus.res_data;
      carry      = bus.res_carry;
      done_alu_a = bus.alu_a;
   endtask

   task automatic release_result();
      bus.res_ready = 1'b1;
      @(posedge clk);
      #1;
      bus.res_ready = 1'b0;
   endtask

   task automatic test_reset();
      repeat (2) @(posedge clk);
      #1;
      n_total += 7;
      if (bus.in_ready !== 1'b1) $display("FAIL rst_in_ready got %b want 1", bus.in_ready);
      else n_pass++;
      if (bus.res_valid !== 1'b0) $display("FAIL rst_res_valid got %b want 0", bus.res_valid);
      else n_pass++;
      if (bus.res_data !== 32'd0) $display("FAIL rst_res_data got %h want 0", bus.res_data);
      else n_pass++;
      if (bus.res_carry !== 1'b0) $display("FAIL rst_res_carry got %b want 0", bus.res_carry);
      else n_pass++;
      if (bus.alu_func !== 3'b000) $display("FAIL rst_alu_func got %b want 000", bus.alu_func);
      else n_pass++;
      if (bus.alu_a !== 32'd0) $display("FAIL rst_alu_a got %h want 0", bus.alu_a);
      else n_pass++;
      if (bus.alu_b !== 32'd0) $display("FAIL rst_alu_b got %h want 0", bus.alu_b);
      else n_pass++;
      @(negedge clk);
      rst_n = 1'b1;
      // res_ready while nothing is pending must be harmless
      release_result();
      n_total += 2;
      if (bus.in_ready !== 1'b1) $display("FAIL idle_rdy_in_ready got %b want 1", bus.in_ready);
      else n_pass++;
      if (bus.res_valid !== 1'b0) $display("FAIL idle_rdy_res_valid got %b want 0", bus.res_valid);
      else n_pass++;
   endtask

   task automatic test_single_ops();
      logic [3:0]  ops [5]   = '{4'b0000, 4'b0001, 4'b0111, 4'b0100, 4'b0010};
      logic [31:0] as  [5]   = '{32'hFFFF_FFFF, 32'd5, 32'd5, 32'hF0F0_F0F0, 32'hF0F0_F0F0};
      logic [31:0] bs  [5]   = '{32'h0000_0001, 32'd7, 32'd7, 32'hFF00_FF00, 32'hFF00_FF00};
      logic [31:0] exd [5]   = '{32'h0000_0000, 32'hFFFF_FFFE, 32'h0, 32'h0FF0_0FF0, 32'hF000_F000};
      logic        exc [5]   = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
      int lat;
      logic [31:0] d, da;
      logic c;
      logic [2:0] f;
      for (int i = 0; i < 5; i++) begin
         do_op(ops[i], as[i], bs[i], lat, d, c, f, da);
         n_total += 5;
         if (lat != 2) $display("FAIL single%0d_lat got %0d want 2", i, lat);
         else n_pass++;
         if (d !== exd[i]) $display("FAIL single%0d_data got %h want %h", i, d, exd[i]);
         else n_pass++;
         if (c !== exc[i]) $display("FAIL single%0d_carry got %b want %b", i, c, exc[i]);
         else n_pass++;
         if (f !== ops[i][2:0]) $display("FAIL single%0d_func got %b want %b", i, f, ops[i][2:0]);
         else n_pass++;
         if (da !== as[i]) $display("FAIL single%0d_done_alu_a got %h want %h", i, da, as[i]);
         else n_pass++;
         release_result();
      end
   endtask

   task automatic test_shift();
      logic [3:0]  ops [4] = '{4'b1000, 4'b1000, 4'b1001, 4'b1000};
      logic [31:0] as  [4] = '{32'h8000_0001, 32'h8000_0001, 32'hC000_0000, 32'h0000_0003};
      logic [31:0] bs  [4] = '{32'd4, 32'd0, 32'd1, 32'd1};
      int          sl  [4] = '{5, 1, 2, 2};
      logic [31:0] sd  [4] = '{32'h0800_0000, 32'h8000_0001, 32'h8000_0000, 32'h0000_0001};
      logic        sc  [4] = '{1'b0, 1'b0, 1'b1, 1'b1};
      logic [2:0]  sf  [4] = '{3'b110, 3'b000, 3'b000, 3'b110};
      int lat, elat;
      logic [31:0] d, da, ed;
      logic c, ec;
      logic [2:0] f, ef;
      for (int i = 0; i < 4; i++) begin
         elat = ShiftEn ? sl[i] : 1;
         ed   = ShiftEn ? sd[i] : 32'd0;
         ec   = ShiftEn ? sc[i] : 1'b0;
         ef   = ShiftEn ? sf[i] : 3'b000;
         do_op(ops[i], as[i], bs[i], lat, d, c, f, da);
         n_total += 4;
         if (lat != elat) $display("FAIL shift%0d_lat got %0d want %0d", i, lat, elat);
         else n_pass++;
         if (d !== ed) $display("FAIL shift%0d_data got %h want %h", i, d, ed);
         else n_pass++;
         if (c !== ec) $display("FAIL shift%0d_carry got %b want %b", i, c, ec);
         else n_pass++;
         if (f !== ef) $display("FAIL shift%0d_func got %b want %b", i, f, ef);
         else n_pass++;
         release_result();
      end
   endtask

   task automatic test_illegal();
      logic [3:0] ops [3] = '{4'b1100, 4'b1111, 4'b1010};
      int lat;
      logic [31:0] d, da;
      logic c;
      logic [2:0] f;
      for (int i = 0; i < 3; i++) begin
         do_op(ops[i], 32'hDEAD_BEEF, 32'h0000_0003, lat, d, c, f, da);
         n_total += 3;
         if (lat != 1) $display("FAIL illegal%0d_lat got %0d want 1", i, lat);
         else n_pass++;
         if (d !== 32'd0) $display("FAIL illegal%0d_data got %h want 0", i, d);
         else n_pass++;
         if (c !== 1'b0) $display("FAIL illegal%0d_carry got %b want 0", i, c);
         else n_pass++;
         release_result();
      end
   endtask

   task automatic test_hold();
      int lat;
      logic [31:0] d, da;
      logic c;
      logic [2:0] f;
      do_op(4'b0000, 32'hFFFF_FFFF, 32'h1, lat, d, c, f, da);
      n_total += 2;
      if (lat != 2) $display("FAIL hold_lat got %0d want 2", lat);
      else n_pass++;
      if (c !== 1'b1) $display("FAIL hold_carry got %b want 1", c);
      else n_pass++;
      // a new command offered during DONE must be ignored
      bus.in_valid = 1'b1;
      bus.in_op    = 4'b0011;
      bus.in_a     = 32'h1234_5678;
      bus.in_b     = 32'h1;
      for (int i = 0; i < 3; i++) begin
         @(posedge clk);
         #1;
         n_total += 4;
         if (bus.res_valid !== 1'b1) $display("FAIL hold%0d_valid got %b want 1", i, bus.res_valid);
         else n_pass++;
         if (bus.res_data !== 32'd0) $display("FAIL hold%0d_data got %h want 0", i, bus.res_data);
         else n_pass++;
         if (bus.res_carry !== 1'b1) $display("FAIL hold%0d_carry got %b want 1", i, bus.res_carry);
         else n_pass++;
         if (bus.in_ready !== 1'b0) $display("FAIL hold%0d_in_ready got %b want 0", i, bus.in_ready);
         else n_pass++;
      end
      bus.in_valid = 1'b0;
      release_result();
      n_total += 2;
      if (bus.in_ready !== 1'b1) $display("FAIL hold_rel_in_ready got %b want 1", bus.in_ready);
      else n_pass++;
      if (bus.res_valid !== 1'b0) $display("FAIL hold_rel_valid got %b want 0", bus.res_valid);
      else n_pass++;
   endtask

   task automatic test_back_to_back();
      int lat;
      logic [31:0] d, da;
      logic c;
      logic [2:0] f;
      do_op(4'b0011, 32'h1234_0000, 32'h0000_5678, lat, d, c, f, da);
      release_result();
      n_total += 2;
      if (d !== 32'h1234_5678) $display("FAIL b2b0_data got %h want 12345678", d);
      else n_pass++;
      if (lat != 2) $display("FAIL b2b0_lat got %0d want 2", lat);
      else n_pass++;
      do_op(4'b0001, 32'd10, 32'd3, lat, d, c, f, da);
      release_result();
      n_total += 3;
      if (d !== 32'd7) $display("FAIL b2b1_data got %h want 7", d);
      else n_pass++;
      if (c !== 1'b0) $display("FAIL b2b1_carry got %b want 0", c);
      else n_pass++;
      if (lat != 2) $display("FAIL b2b1_lat got %0d want 2", lat);
      else n_pass++;
   endtask

   task automatic test_reset_abort();
      int lat;
      logic [31:0] d, da;
      logic c;
      logic [2:0] f;
      bus.in_valid = 1'b1;
`ifdef ALU_SEQ_SHIFT_EN
      // 10-bit SRL, reset during the second SHIFT cycle
      bus.in_op = 4'b1000;
      bus.in_a  = 32'hFFFF_FFFF;
      bus.in_b  = 32'd10;
      @(posedge clk);
      #1;
      bus.in_valid = 1'b0;
      @(posedge clk);
      #1;
`else
      // no shifter: abort in the middle of EXEC instead
      bus.in_op = 4'b0000;
      bus.in_a  = 32'h0000_0010;
      bus.in_b  = 32'h0000_0020;
      @(posedge clk);
      #1;
      bus.in_valid = 1'b0;
`endif
      rst_n = 1'b0;
      #1;
      n_total += 3;
      if (bus.res_valid !== 1'b0) $display("FAIL abort_valid got %b want 0", bus.res_valid);
      else n_pass++;
      if (bus.in_ready !== 1'b1) $display("FAIL abort_in_ready got %b want 1", bus.in_ready);
      else n_pass++;
      if (bus.alu_func !== 3'b000) $display("FAIL abort_func got %b want 000", bus.alu_func);
      else n_pass++;
      @(negedge clk);
      rst_n = 1'b1;
      do_op(4'b0000, 32'd3, 32'd4, lat, d, c, f, da);
      release_result();
      n_total += 3;
      if (lat != 2) $display("FAIL after_abort_lat got %0d want 2", lat);
      else n_pass++;
      if (d !== 32'd7) $display("FAIL after_abort_data got %h want 7", d);
      else n_pass++;
      if (c !== 1'b0) $display("FAIL after_abort_carry got %b want 0", c);
      else n_pass++;
   endtask

   initial begin
      bus.in_valid  = 1'b0;
      bus.in_op     = 4'd0;
      bus.in_a      = 32'd0;
      bus.in_b      = 32'd0;
      bus.res_ready = 1'b0;
      test_reset();
      test_single_ops();
      test_shift();
      test_illegal();
      test_hold();
      test_back_to_back();
      test_reset_abort();
      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
